// File: rtl/bodylength_rx_if.sv
// Byte-stream and result bundle for the FIX BodyLength receiver.
//   master : byte source / result consumer (drives data_i, valid_i, abort_i)
//   slave  : the receiver (drives length_o, length_valid_o, done_o, error_o, err_code_o)
interface bodylength_rx_if #(
  parameter int unsigned VALUE_WIDTH = 32
);
  logic                   abort_i;
  logic [7:0]             data_i;
  logic                   valid_i;
  logic [VALUE_WIDTH-1:0] length_o;
  logic                   length_valid_o;
  logic                   done_o;
  logic                   error_o;
  logic [2:0]             err_code_o;

  modport master (
    output abort_i, data_i, valid_i,
    input  length_o, length_valid_o, done_o, error_o, err_code_o
  );

  modport slave (
    input  abort_i, data_i, valid_i,
    output length_o, length_valid_o, done_o, error_o, err_code_o
  );
endinterface

// File: rtl/bodylength_rx.sv
// FIX BodyLength (tag 9) receiver.
// Decodes the ASCII tag-9 value, counts the message body and checks that
// the body ends on an SOH exactly at the declared length followed by "10=".
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous reset, active low
//   bus  - bodylength_rx_if.slave: abort_i, data_i, valid_i in;
//          length_o, length_valid_o, done_o, error_o, err_code_o out
// Error codes: 1 bad/empty digits, 2 too many digits, 3 length mismatch,
//              4 trailer mismatch.
module bodylength_rx #(
  parameter int unsigned VALUE_WIDTH = 32,
  parameter int unsigned MAX_DIGITS  = 7
) (
  input  logic            clk,
  input  logic            rst,
  bodylength_rx_if.slave  bus
);

  localparam int unsigned DW = $clog2(MAX_DIGITS + 1);
  localparam logic [7:0]  SOH = 8'h01;

  typedef enum logic [2:0] {
    SEEK, TAG9, DIGITS, COUNT, TRAIL1, TRAIL0, TRAILEQ
  } state_t;

  state_t                 state_q, state_d;
  logic                   prev_soh_q, prev_soh_d;
  logic [VALUE_WIDTH-1:0] acc_q, acc_d;
  logic [DW-1:0]          dig_q, dig_d;
  logic [VALUE_WIDTH-1:0] cnt_q, cnt_d;
  logic [VALUE_WIDTH-1:0] len_q, len_d;
  logic [2:0]             code_q, code_d;
  logic                   lv_q, lv_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic                   is_digit;
  logic                   is_soh;
  logic [VALUE_WIDTH-1:0] acc_next;
  logic [VALUE_WIDTH-1:0] cnt_inc;
  logic                   fail;
  logic [2:0]             fail_code;

  assign is_digit = (bus.data_i >= 8'h30) && (bus.data_i <= 8'h39);
  assign is_soh   = (bus.data_i == SOH);
  // acc*10 as (acc<<3)+(acc<<1), wrapping at VALUE_WIDTH
  assign acc_next = (acc_q << 3) + (acc_q << 1) + VALUE_WIDTH'(bus.data_i - 8'h30);
  assign cnt_inc  = cnt_q + VALUE_WIDTH'(1);

  always_comb begin
    state_d    = state_q;
    prev_soh_d = prev_soh_q;
    acc_d      = acc_q;
    dig_d      = dig_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    code_d     = code_q;
    lv_d       = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    fail       = 1'b0;
    fail_code  = 3'd0;

    if (bus.abort_i) begin
      state_d    = SEEK;
      prev_soh_d = 1'b1;
    end else if (bus.valid_i) begin
      prev_soh_d = is_soh;
      unique case (state_q)
        SEEK: begin
          if (bus.data_i == "9" && prev_soh_q) state_d = TAG9;
        end
        TAG9: begin
          if (bus.data_i == "=") begin
            state_d = DIGITS;
            acc_d   = '0;
            dig_d   = '0;
          end else begin
            state_d = SEEK;
          end
        end
        DIGITS: begin
          if (is_digit) begin
            if (dig_q == DW'(MAX_DIGITS)) begin
              fail      = 1'b1;
              fail_code = 3'd2;
            end else begin
              acc_d = acc_next;
              dig_d = dig_q + DW'(1);
            end
          end else if (is_soh && dig_q != '0) begin
            len_d   = acc_q;
            lv_d    = 1'b1;
            cnt_d   = '0;
            state_d = (acc_q != '0) ? COUNT : TRAIL1;
          end else begin
            fail      = 1'b1;
            fail_code = 3'd1;
          end
        end
        COUNT: begin
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            if (is_soh) begin
              state_d = TRAIL1;
            end else begin
              fail      = 1'b1;
              fail_code = 3'd3;
            end
          end
        end
        TRAIL1: begin
          if (bus.data_i == "1") state_d = TRAIL0;
          else begin
            fail      = 1'b1;
            fail_code = 3'd4;
          end
        end
        TRAIL0: begin
          if (bus.data_i == "0") state_d = TRAILEQ;
          else begin
            fail      = 1'b1;
            fail_code = 3'd4;
          end
        end
        TRAILEQ: begin
          if (bus.data_i == "=") begin
            done_d     = 1'b1;
            state_d    = SEEK;
            prev_soh_d = 1'b1;
          end else begin
            fail      = 1'b1;
            fail_code = 3'd4;
          end
        end
        default: state_d = SEEK;
      endcase

      if (fail) begin
        err_d      = 1'b1;
        code_d     = fail_code;
        state_d    = SEEK;
        prev_soh_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= SEEK;
      prev_soh_q <= 1'b1;
      acc_q      <= '0;
      dig_q      <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      code_q     <= '0;
      lv_q       <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_soh_q <= prev_soh_d;
      acc_q      <= acc_d;
      dig_q      <= dig_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      code_q     <= code_d;
      lv_q       <= lv_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.length_o       = len_q;
  assign bus.length_valid_o = lv_q;
  assign bus.done_o         = done_q;
  assign bus.error_o        = err_q;
  assign bus.err_code_o     = code_q;

endmodule

// File: tb/tb_bodylength_rx.sv
module tb_bodylength_rx;

  localparam logic [7:0] SOH = 8'h01;
  localparam int K_NONE = 0, K_LV = 1, K_DONE = 2, K_ERR = 3;

  typedef struct {
    int          kind;
    int unsigned val;
    int unsigned cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int unsigned cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int gap = 0;
  exp_t sbq[$];

  bodylength_rx_if #(.VALUE_WIDTH(32)) bus ();

  bodylength_rx #(.VALUE_WIDTH(32), .MAX_DIGITS(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expected pulses in order and checks kind, cycle and value.
  always @(negedge clk) begin
    if (rst && (bus.length_valid_o || bus.done_o || bus.error_o)) begin
      int k;
      int unsigned v;
      exp_t e;
      chk("onehot", 32'(bus.length_valid_o) + 32'(bus.done_o) + 32'(bus.error_o), 1);
      k = bus.length_valid_o ? K_LV : (bus.done_o ? K_DONE : K_ERR);
      v = (k == K_ERR) ? 32'(bus.err_code_o) : bus.length_o;
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pulse: got kind %0d value %0d expected none (cyc %0d)", k, v, cyc);
      end else begin
        e = sbq.pop_front();
        chk("kind", k, e.kind);
        chk("cycle", cyc, e.cyc);
        chk("value", v, e.val);
      end
    end
  end

  task automatic send(input logic [7:0] b, input int kind, input int unsigned val);
    exp_t e;
    bus.data_i  = b;
    bus.valid_i = 1'b1;
    if (kind != K_NONE) begin
      e.kind = kind;
      e.val  = val;
      e.cyc  = cyc + 1;
      sbq.push_back(e);
    end
    @(negedge clk);
    bus.valid_i = 1'b0;
    bus.data_i  = 8'h00;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i], K_NONE, 0);
  endtask

  // "9=5",SOH,"35=0",SOH,"10="
  task automatic msg_basic();
    send_str("9=5");
    send(SOH, K_LV, 5);
    send_str("35=0");
    send(SOH, K_NONE, 0);
    send_str("10");
    send("=", K_DONE, 5);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_length"}, bus.length_o, 0);
    chk({tag, "_lv"}, bus.length_valid_o, 0);
    chk({tag, "_done"}, bus.done_o, 0);
    chk({tag, "_err"}, bus.error_o, 0);
    chk({tag, "_code"}, bus.err_code_o, 0);
  endtask

  initial begin
    bus.abort_i = 1'b0;
    bus.valid_i = 1'b0;
    bus.data_i  = 8'h00;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    rst = 1'b1;
    @(negedge clk);

    // Basic message, then a back-to-back repeat
    msg_basic();
    msg_basic();

    // Body length mismatch
    send_str("9=5");
    send(SOH, K_LV, 5);
    send_str("35=0");
    send("X", K_ERR, 3);

    // Too many digits
    send_str("9=1234567");
    send("8", K_ERR, 2);
    send(SOH, K_NONE, 0);

    // Empty value, then non-digit in value
    send_str("9=");
    send(SOH, K_ERR, 1);
    send_str("9=1");
    send("a", K_ERR, 1);

    // Zero length: straight to trailer
    send_str("9=0");
    send(SOH, K_LV, 0);
    send_str("10");
    send("=", K_DONE, 0);

    // Idle gaps between bytes
    gap = 3;
    msg_basic();
    gap = 0;

    // Abort in COUNT (with a simultaneous valid byte), then a clean message
    send_str("9=5");
    send(SOH, K_LV, 5);
    send_str("35");
    bus.abort_i = 1'b1;
    bus.valid_i = 1'b1;
    bus.data_i  = "=";
    @(negedge clk);
    bus.abort_i = 1'b0;
    bus.valid_i = 1'b0;
    @(negedge clk);
    chk("abort_length_kept", bus.length_o, 5);
    chk("abort_code_kept", bus.err_code_o, 1);
    msg_basic();

    // '9' not preceded by SOH is ignored; checksum bytes ignored in SEEK
    send_str("X9=5");
    send(SOH, K_NONE, 0);
    send_str("9=3");
    send(SOH, K_LV, 3);
    send_str("ab");
    send(SOH, K_NONE, 0);
    send_str("10");
    send("=", K_DONE, 3);
    send_str("123");
    send(SOH, K_NONE, 0);

    // Trailer mismatch
    send_str("9=0");
    send(SOH, K_LV, 0);
    send("1", K_NONE, 0);
    send("1", K_ERR, 4);

    // Reset in DIGITS clears everything at once
    send_str("9=12");
    rst = 1'b0;
    #1;
    chk_idle_outputs("midreset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    msg_basic();

    repeat (4) @(negedge clk);
    chk("drain", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
